// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
//   Registered ALU sitting between operand fetch and writeback. One operation
//   is in flight at a time. Single-cycle ops (logic, add/sub, shifts, signed
//   compare) produce a result one cycle after acceptance; MUL runs an
//   iterative shift-add multiply over WIDTH cycles. Results and flags are held
//   while the consumer applies back-pressure.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_valid   operands/op valid        in_ready   block can accept
//   num1       operand A                num2       operand B / shift amount
//   op         4-bit operation select
//   out_valid  result held on out       out_ready  consumer accepts result
//   out        WIDTH-bit result
//   z,n,c,v    zero, negative, carry, signed-overflow flags
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter  int WIDTH = 64,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             v
);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLL   = 4'b0011;
    localparam logic [3:0] OP_SRL   = 4'b0100;
    localparam logic [3:0] OP_SRA   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_PASSB = 4'b0111;
    localparam logic [3:0] OP_MUL   = 4'b1000;
    localparam logic [3:0] OP_SLT   = 4'b1001;
    localparam logic [3:0] OP_NOR   = 4'b1100;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } stateT;

    stateT            state;
    stateT            nextState;
    logic             accept;
    logic [SHW-1:0]   shAmt;
    logic [WIDTH:0]   addWide;
    logic [WIDTH-1:0] subOut;
    logic [WIDTH-1:0] aluOut;
    logic             aluC;
    logic             aluV;
    logic [WIDTH-1:0] mulA;
    logic [WIDTH-1:0] mulB;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] stepSum;
    logic [SHW-1:0]   stepCount;
    logic             lastStep;
    logic [WIDTH-1:0] outReg;
    logic             zReg;
    logic             nReg;
    logic             cReg;
    logic             vReg;

    // Handshake decode. in_ready is forced low while reset is held so the
    // upstream stage cannot hand us an operation that would be dropped, and
    // it follows out_ready combinationally in DONE so a result can drain and
    // a new operation enter on the same edge.
    assign in_ready  = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);

    assign out = outReg;
    assign z   = zReg;
    assign n   = nReg;
    assign c   = cReg;
    assign v   = vReg;

    // Single-cycle datapath. Every op except MUL is evaluated straight off the
    // input operands so the result can be captured at the accepting edge.
    // Carry for SUB means "no borrow", i.e. A >= B unsigned. Overflow is the
    // classic sign test: operands that agree in sign (ADD) or disagree (SUB)
    // producing a result whose sign differs from A.
    always_comb begin
        aluOut  = '0;
        aluC    = 1'b0;
        aluV    = 1'b0;
        addWide = {1'b0, num1} + {1'b0, num2};
        subOut  = num1 - num2;
        shAmt   = num2[SHW-1:0];
        case (op)
            OP_AND:   aluOut = num1 & num2;
            OP_OR:    aluOut = num1 | num2;
            OP_NOR:   aluOut = ~(num1 | num2);
            OP_PASSB: aluOut = num2;
            OP_ADD: begin
                aluOut = addWide[WIDTH-1:0];
                aluC   = addWide[WIDTH];
                aluV   = (num1[WIDTH-1] == num2[WIDTH-1]) &&
                         (addWide[WIDTH-1] != num1[WIDTH-1]);
            end
            OP_SUB: begin
                aluOut = subOut;
                aluC   = (num1 >= num2);
                aluV   = (num1[WIDTH-1] != num2[WIDTH-1]) &&
                         (subOut[WIDTH-1] != num1[WIDTH-1]);
            end
            OP_SLL:   aluOut = num1 << shAmt;
            OP_SRL:   aluOut = num1 >> shAmt;
            OP_SRA:   aluOut = $unsigned($signed(num1) >>> shAmt);
            OP_SLT:   aluOut = {{(WIDTH-1){1'b0}}, ($signed(num1) < $signed(num2))};
            default:  aluOut = '0;
        endcase
    end

    // One shift-add multiply step: add the shifted multiplicand when the
    // current multiplier LSB is set. The final step's sum is the product.
    assign stepSum  = acc + (mulB[0] ? mulA : '0);
    assign lastStep = (stepCount == SHW'(WIDTH - 1));

    // State register. Reset aborts any multiply in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic. DONE with out_ready behaves like IDLE: an operation
    // offered on that cycle is taken immediately, otherwise we drop to IDLE.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (op == OP_MUL) nextState = MUL;
                    else              nextState = DONE;
                end
            end
            MUL: begin
                if (lastStep) nextState = DONE;
            end
            DONE: begin
                if (accept) begin
                    if (op == OP_MUL) nextState = MUL;
                    else              nextState = DONE;
                end else if (out_ready) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Result, flag and multiplier registers. Operands are only sampled on an
    // accepting edge; afterwards num1/num2/op are ignored. A single-cycle op
    // writes its result straight away, a MUL loads the iteration registers
    // and writes the product on its last step. Outside those two cases every
    // register holds, which is what keeps the result stable under
    // back-pressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outReg    <= '0;
            zReg      <= 1'b1;
            nReg      <= 1'b0;
            cReg      <= 1'b0;
            vReg      <= 1'b0;
            mulA      <= '0;
            mulB      <= '0;
            acc       <= '0;
            stepCount <= '0;
        end else if (accept) begin
            if (op == OP_MUL) begin
                mulA      <= num1;
                mulB      <= num2;
                acc       <= '0;
                stepCount <= '0;
            end else begin
                outReg <= aluOut;
                zReg   <= (aluOut == '0);
                nReg   <= aluOut[WIDTH-1];
                cReg   <= aluC;
                vReg   <= aluV;
            end
        end else if (state == MUL) begin
            if (lastStep) begin
                outReg <= stepSum;
                zReg   <= (stepSum == '0);
                nReg   <= stepSum[WIDTH-1];
                cReg   <= 1'b0;
                vReg   <= 1'b0;
            end else begin
                acc       <= stepSum;
                mulA      <= mulA << 1;
                mulB      <= mulB >> 1;
                stepCount <= stepCount + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
//   Self-checking bench for alu_seq. An 8-bit instance gets a directed table,
//   back-pressure and reset-abort sequences and random ops against an
//   arithmetic reference model; a 64-bit instance gets a random regression of
//   the legacy ops against the same model.
// ---------------------------------------------------------------------------
module tb_alu_seq;

    typedef struct {
        logic [63:0] out;
        logic [3:0]  flags;
        logic        sawReady;
    } res_t;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] expOut;
        logic [3:0]  expFlags;
        int          expLat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;

    logic        inValid8, inReady8, outValid8, outReady8;
    logic [7:0]  numA8, numB8, res8;
    logic [3:0]  op8;
    logic        z8, n8, c8, v8;

    logic        inValid64, inReady64, outValid64, outReady64;
    logic [63:0] numA64, numB64, res64;
    logic [3:0]  op64;
    logic        z64, n64, c64, v64;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(inValid8), .in_ready(inReady8),
        .num1(numA8), .num2(numB8), .op(op8),
        .out_valid(outValid8), .out_ready(outReady8),
        .out(res8), .z(z8), .n(n8), .c(c8), .v(v8)
    );

    alu_seq #(.WIDTH(64)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(inValid64), .in_ready(inReady64),
        .num1(numA64), .num2(numB64), .op(op64),
        .out_valid(outValid64), .out_ready(outReady64),
        .out(res64), .z(z64), .n(n64), .c(c64), .v(v64)
    );

    // Reference model: plain arithmetic on exact (66-bit) values, with carry
    // and overflow read off as "the exact result left the representable range".
    function automatic res_t model(input int w, input logic [3:0] op,
                                   input logic [63:0] aIn, input logic [63:0] bIn);
        res_t r;
        logic [63:0] mask, a, b;
        logic [65:0] ua, ub, uexact, umod;
        logic signed [65:0] sa, sb, sexact, smax, smin;
        int sh;
        logic cFlag, vFlag;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        a = aIn & mask;
        b = bIn & mask;
        ua = {2'b00, a};
        ub = {2'b00, b};
        umod = 66'd1 << w;
        sa = $signed(ua);
        sb = $signed(ub);
        if (a[w-1]) sa = sa - $signed(umod);
        if (b[w-1]) sb = sb - $signed(umod);
        smax = $signed(66'd1 << (w - 1)) - 66'sd1;
        smin = -$signed(66'd1 << (w - 1));
        sh = int'(b % 64'(w));
        cFlag = 1'b0;
        vFlag = 1'b0;
        r.out = '0;
        r.sawReady = 1'b0;
        case (op)
            4'b0000: r.out = a & b;
            4'b0001: r.out = a | b;
            4'b1100: r.out = ~(a | b) & mask;
            4'b0111: r.out = b;
            4'b0010: begin
                uexact = ua + ub;
                r.out = uexact[63:0] & mask;
                cFlag = (uexact >= umod);
                sexact = sa + sb;
                vFlag = (sexact > smax) || (sexact < smin);
            end
            4'b0110: begin
                r.out = (a - b) & mask;
                cFlag = (a >= b);
                sexact = sa - sb;
                vFlag = (sexact > smax) || (sexact < smin);
            end
            4'b0011: r.out = (a << sh) & mask;
            4'b0100: r.out = a >> sh;
            4'b0101: begin
                sexact = sa >>> sh;
                r.out = sexact[63:0] & mask;
            end
            4'b1001: r.out = (sa < sb) ? 64'd1 : 64'd0;
            4'b1000: r.out = (a * b) & mask;
            default: r.out = '0;
        endcase
        r.flags = {(r.out == 64'd0), r.out[w-1], cFlag, vFlag};
        return r;
    endfunction

    function automatic logic isValid(input int w);
        return (w == 8) ? outValid8 : outValid64;
    endfunction

    function automatic logic isReady(input int w);
        return (w == 8) ? inReady8 : inReady64;
    endfunction

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Offer one operation with out_ready high, scramble the inputs after the
    // accepting edge, then wait (bounded) for out_valid. Latency counts
    // cycles from the accepting edge to the first cycle out_valid is seen.
    task automatic applyStimulus(input int w, input logic [3:0] op,
                                 input logic [63:0] a, input logic [63:0] b,
                                 output res_t r, output int lat);
        int guard;
        if (w == 8) begin
            op8 = op; numA8 = a[7:0]; numB8 = b[7:0]; inValid8 = 1'b1; outReady8 = 1'b1;
        end else begin
            op64 = op; numA64 = a; numB64 = b; inValid64 = 1'b1; outReady64 = 1'b1;
        end
        #1;
        guard = 0;
        while (!isReady(w) && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        if (w == 8) begin
            inValid8 = 1'b0; op8 = 4'($urandom); numA8 = 8'($urandom); numB8 = 8'($urandom);
        end else begin
            inValid64 = 1'b0; op64 = 4'($urandom);
            numA64 = {$urandom, $urandom}; numB64 = {$urandom, $urandom};
        end
        r.sawReady = 1'b0;
        lat = 1;
        while (!isValid(w) && lat < 200) begin
            if (isReady(w)) r.sawReady = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        if (w == 8) begin
            r.out = {56'd0, res8};  r.flags = {z8, n8, c8, v8};
        end else begin
            r.out = res64;          r.flags = {z64, n64, c64, v64};
        end
    endtask

    // Let the 8-bit instance drain its result and return to IDLE.
    task automatic drain8();
        inValid8 = 1'b0;
        outReady8 = 1'b1;
        @(posedge clk); #1;
    endtask

    // Watchdog so the run always ends even if the DUT wedges.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, directed table, back-pressure, reset abort,
    // random 8-bit ops, random 64-bit legacy ops.
    initial begin
        vec_t tbl[17];
        res_t r, e;
        int lat, expLat;
        logic [3:0] rop;
        logic [63:0] ra, rb;
        logic [3:0] legacy[6];

        legacy = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};

        tbl[0]  = '{4'b0010, 64'h7F, 64'h01, 64'h80, 4'b0101, 1};
        tbl[1]  = '{4'b0110, 64'h05, 64'h05, 64'h00, 4'b1010, 1};
        tbl[2]  = '{4'b0110, 64'h03, 64'h05, 64'hFE, 4'b0100, 1};
        tbl[3]  = '{4'b1000, 64'h0D, 64'h0B, 64'h8F, 4'b0100, 9};
        tbl[4]  = '{4'b0101, 64'h90, 64'hF3, 64'hF2, 4'b0100, 1};
        tbl[5]  = '{4'b0011, 64'hA5, 64'h08, 64'hA5, 4'b0100, 1};
        tbl[6]  = '{4'b1001, 64'h80, 64'h01, 64'h01, 4'b0000, 1};
        tbl[7]  = '{4'b1111, 64'h12, 64'h34, 64'h00, 4'b1000, 1};
        tbl[8]  = '{4'b0000, 64'hF0, 64'h3C, 64'h30, 4'b0000, 1};
        tbl[9]  = '{4'b0001, 64'h0F, 64'h30, 64'h3F, 4'b0000, 1};
        tbl[10] = '{4'b1100, 64'h0F, 64'hF0, 64'h00, 4'b1000, 1};
        tbl[11] = '{4'b0111, 64'h00, 64'hC3, 64'hC3, 4'b0100, 1};
        tbl[12] = '{4'b0100, 64'h80, 64'h07, 64'h01, 4'b0000, 1};
        tbl[13] = '{4'b0010, 64'hFF, 64'h01, 64'h00, 4'b1010, 1};
        tbl[14] = '{4'b0110, 64'h80, 64'h01, 64'h7F, 4'b0011, 1};
        tbl[15] = '{4'b1000, 64'hFF, 64'hFF, 64'h01, 4'b0000, 9};
        tbl[16] = '{4'b1001, 64'h01, 64'h80, 64'h00, 4'b1000, 1};

        rst = 1'b1;
        inValid8 = 1'b0; outReady8 = 1'b1; numA8 = '0; numB8 = '0; op8 = '0;
        inValid64 = 1'b0; outReady64 = 1'b1; numA64 = '0; numB64 = '0; op64 = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset out", {56'd0, res8}, 64'd0);
        checkOutput("reset flags", {60'd0, z8, n8, c8, v8}, 64'h8);
        checkOutput("reset out_valid", {63'd0, outValid8}, 64'd0);
        checkOutput("reset in_ready", {63'd0, inReady8}, 64'd0);
        checkOutput("reset out64", res64, 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("post-reset in_ready", {63'd0, inReady8}, 64'd1);
        checkOutput("post-reset out_valid", {63'd0, outValid8}, 64'd0);

        $display("[TB] directed table");
        for (int i = 0; i < 17; i++) begin
            applyStimulus(8, tbl[i].op, tbl[i].a, tbl[i].b, r, lat);
            checkOutput($sformatf("tbl%0d out", i), r.out, tbl[i].expOut);
            checkOutput($sformatf("tbl%0d flags", i), {60'd0, r.flags}, {60'd0, tbl[i].expFlags});
            checkOutput($sformatf("tbl%0d latency", i), 64'(lat), 64'(tbl[i].expLat));
            checkOutput($sformatf("tbl%0d in_ready in DONE", i), {63'd0, inReady8}, 64'd1);
            if (tbl[i].op == 4'b1000)
                checkOutput($sformatf("tbl%0d in_ready during MUL", i), {63'd0, r.sawReady}, 64'd0);
        end

        $display("[TB] back-pressure");
        drain8();
        op8 = 4'b0000; numA8 = 8'hF0; numB8 = 8'h3C; inValid8 = 1'b1; outReady8 = 1'b0;
        @(posedge clk); #1;
        op8 = 4'b0001; numA8 = 8'h0F; numB8 = 8'h30;
        checkOutput("bp first out_valid", {63'd0, outValid8}, 64'd1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("bp hold%0d out", k), {56'd0, res8}, 64'h30);
            checkOutput($sformatf("bp hold%0d out_valid", k), {63'd0, outValid8}, 64'd1);
            checkOutput($sformatf("bp hold%0d in_ready", k), {63'd0, inReady8}, 64'd0);
        end
        outReady8 = 1'b1;
        #1;
        checkOutput("bp release in_ready", {63'd0, inReady8}, 64'd1);
        @(posedge clk); #1;
        inValid8 = 1'b0;
        checkOutput("bp next out", {56'd0, res8}, 64'h3F);
        checkOutput("bp next out_valid", {63'd0, outValid8}, 64'd1);
        @(posedge clk); #1;
        checkOutput("bp drained out_valid", {63'd0, outValid8}, 64'd0);

        $display("[TB] reset during MUL");
        op8 = 4'b1000; numA8 = 8'd13; numB8 = 8'd11; inValid8 = 1'b1; outReady8 = 1'b1;
        @(posedge clk); #1;
        inValid8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("abort out", {56'd0, res8}, 64'd0);
        checkOutput("abort z", {63'd0, z8}, 64'd1);
        checkOutput("abort out_valid", {63'd0, outValid8}, 64'd0);
        checkOutput("abort in_ready", {63'd0, inReady8}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checkOutput("abort release in_ready", {63'd0, inReady8}, 64'd1);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("abort no stale result", {63'd0, outValid8}, 64'd0);
        applyStimulus(8, 4'b0010, 64'h22, 64'h33, r, lat);
        checkOutput("abort next ADD out", r.out, 64'h55);
        checkOutput("abort next ADD latency", 64'(lat), 64'd1);

        $display("[TB] random 8-bit");
        for (int i = 0; i < 150; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra = 64'($urandom_range(0, 255));
            rb = 64'($urandom_range(0, 255));
            e = model(8, rop, ra, rb);
            expLat = (rop == 4'b1000) ? 9 : 1;
            applyStimulus(8, rop, ra, rb, r, lat);
            checkOutput($sformatf("rnd8 %0d op%0h out", i, rop), r.out, e.out);
            checkOutput($sformatf("rnd8 %0d op%0h flags", i, rop), {60'd0, r.flags}, {60'd0, e.flags});
            checkOutput($sformatf("rnd8 %0d op%0h latency", i, rop), 64'(lat), 64'(expLat));
        end
        drain8();

        $display("[TB] random 64-bit legacy ops");
        for (int i = 0; i < 104; i++) begin
            case (i)
                0: begin rop = 4'b0010; ra = '1; rb = 64'd1; end
                1: begin rop = 4'b0010; ra = 64'h7FFF_FFFF_FFFF_FFFF; rb = 64'd1; end
                2: begin rop = 4'b0110; ra = 64'h8000_0000_0000_0000; rb = 64'd1; end
                3: begin rop = 4'b0110; ra = 64'd3; rb = 64'd5; end
                default: begin
                    rop = legacy[$urandom_range(0, 5)];
                    ra = {$urandom, $urandom};
                    rb = {$urandom, $urandom};
                end
            endcase
            e = model(64, rop, ra, rb);
            applyStimulus(64, rop, ra, rb, r, lat);
            checkOutput($sformatf("rnd64 %0d op%0h out", i, rop), r.out, e.out);
            checkOutput($sformatf("rnd64 %0d op%0h flags", i, rop), {60'd0, r.flags}, {60'd0, e.flags});
            checkOutput($sformatf("rnd64 %0d op%0h latency", i, rop), 64'(lat), 64'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
